// File: rtl/m_load_unit_pkg.sv
// Shared definitions for the M-stage load path: load op codes, FSM states and the
// data-bus address map also used by the store-side checker.
package m_load_unit_pkg;

    localparam logic [2:0] DE_NONE = 3'd0;
    localparam logic [2:0] DE_LW   = 3'd1;
    localparam logic [2:0] DE_LH   = 3'd2;
    localparam logic [2:0] DE_LHU  = 3'd3;
    localparam logic [2:0] DE_LB   = 3'd4;
    localparam logic [2:0] DE_LBU  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

    localparam logic [31:0] DM_BEGIN  = 32'h0000_0000;
    localparam logic [31:0] DM_END    = 32'h0000_2FFF;
    localparam logic [31:0] TC1_BEGIN = 32'h0000_7F00;
    localparam logic [31:0] TC1_END   = 32'h0000_7F0B;
    localparam logic [31:0] TC2_BEGIN = 32'h0000_7F10;
    localparam logic [31:0] TC2_END   = 32'h0000_7F1B;

    function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    // Codes 6 and 7 are unused and behave like DE_NONE.
    function automatic logic is_load_op(input logic [2:0] op);
        return (op == DE_LW) || (op == DE_LH) || (op == DE_LHU) ||
               (op == DE_LB) || (op == DE_LBU);
    endfunction

endpackage

// File: rtl/m_load_unit_if.sv
// Read side of the data bus (DM, TC1, TC2 behind the bridge): req/ack handshake.
interface m_load_unit_if;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;

    modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
    modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/m_load_ext.sv
// Combinational align/extend of a returned bus word according to the load op and
// the low address bits of the access.
module m_load_ext
    import m_load_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  a,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = lane[a];
    assign sel_half = a[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (op)
            DE_LH:   data = {{16{sel_half[15]}}, sel_half};
            DE_LHU:  data = {16'h0000, sel_half};
            DE_LB:   data = {{24{sel_byte[7]}}, sel_byte};
            DE_LBU:  data = {24'h00_0000, sel_byte};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/m_load_unit.sv
// M-stage load unit: address check (AdEL), req/ack bus read with pipeline stall,
// flush draining, timeout, and aligned/extended result for writeback.
module m_load_unit
    import m_load_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [2:0]           DEOp,
    input  logic [31:0]          Addr,
    input  logic                 Req,
    input  logic                 EXC_DMOv,
    m_load_unit_if.master        bus,
    output logic                 stall,
    output logic                 ld_valid,
    output logic [31:0]          ld_data,
    output logic                 EXC_AdEL,
    output logic                 bus_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    ld_state_e   state_reg;
    logic [2:0]  op_reg;
    logic [1:0]  a_reg;
    logic [31:0] rd_addr_reg;
    logic        rd_req_reg;
    logic [CW-1:0] cnt_reg;
    logic        ld_valid_reg;
    logic [31:0] ld_data_reg;
    logic        bus_err_reg;

    logic        valid_op;
    logic        misaligned;
    logic        in_dm;
    logic        in_tc;
    logic        go;
    logic [31:0] ext_data;

    assign valid_op = load && is_load_op(DEOp);
    assign in_dm    = in_range(Addr, DM_BEGIN, DM_END);
    assign in_tc    = in_range(Addr, TC1_BEGIN, TC1_END) || in_range(Addr, TC2_BEGIN, TC2_END);

    always_comb begin
        misaligned = 1'b0;
        case (DEOp)
            DE_LW:          misaligned = |Addr[1:0];
            DE_LH, DE_LHU:  misaligned = Addr[0];
            default:        misaligned = 1'b0;
        endcase
    end

    // Timer registers are word-wide only, so sub-word loads there fault.
    assign EXC_AdEL = valid_op && (EXC_DMOv || misaligned || !(in_dm || in_tc) ||
                                   (in_tc && (DEOp != DE_LW)));
    assign go = valid_op && !EXC_AdEL && !Req;

    always_comb begin
        stall = 1'b0;
        case (state_reg)
            ST_IDLE:  stall = go;
            ST_WAIT:  stall = 1'b1;
            ST_DRAIN: stall = load;
            ST_DONE:  stall = 1'b0;
            default:  stall = 1'b0;
        endcase
    end

    m_load_ext u_ext (
        .op   (op_reg),
        .a    (a_reg),
        .word (bus.rd_data),
        .data (ext_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            op_reg       <= DE_NONE;
            a_reg        <= 2'b00;
            rd_addr_reg  <= 32'h0;
            rd_req_reg   <= 1'b0;
            cnt_reg      <= '0;
            ld_valid_reg <= 1'b0;
            ld_data_reg  <= 32'h0;
            bus_err_reg  <= 1'b0;
        end else begin
            ld_valid_reg <= 1'b0;
            bus_err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (go) begin
                        op_reg      <= DEOp;
                        a_reg       <= Addr[1:0];
                        rd_addr_reg <= {Addr[31:2], 2'b00};
                        rd_req_reg  <= 1'b1;
                        cnt_reg     <= '0;
                        state_reg   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (Req) begin
                        // A flush that coincides with the ack needs no drain: the read is already over.
                        if (bus.rd_ack) begin
                            rd_req_reg <= 1'b0;
                            state_reg  <= ST_IDLE;
                        end else begin
                            state_reg  <= ST_DRAIN;
                        end
                    end else if (bus.rd_ack) begin
                        ld_data_reg  <= ext_data;
                        rd_req_reg   <= 1'b0;
                        ld_valid_reg <= 1'b1;
                        state_reg    <= ST_DONE;
                    end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                        ld_data_reg  <= 32'h0;
                        rd_req_reg   <= 1'b0;
                        ld_valid_reg <= 1'b1;
                        bus_err_reg  <= 1'b1;
                        state_reg    <= ST_DONE;
                    end
                end
                ST_DRAIN: begin
                    if (bus.rd_ack) begin
                        rd_req_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_req  = rd_req_reg;
    assign bus.rd_addr = rd_addr_reg;
    assign ld_valid    = ld_valid_reg;
    assign ld_data     = ld_data_reg;
    assign bus_err     = bus_err_reg;

endmodule

// File: tb/tb_m_load_unit.sv
// Directed bench for m_load_unit: table of load vectors plus hand-written flush,
// timeout and mid-transfer reset sequences.
module tb_m_load_unit;
    import m_load_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        load;
    logic [2:0]  de_op;
    logic [31:0] addr;
    logic        req;
    logic        dmov;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        exc_adel;
    logic        bus_err;

    m_load_unit_if bus ();

    m_load_unit #(.TIMEOUT(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .DEOp     (de_op),
        .Addr     (addr),
        .Req      (req),
        .EXC_DMOv (dmov),
        .bus      (bus),
        .stall    (stall),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .EXC_AdEL (exc_adel),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic        dmov;
        int          delay;
        logic [31:0] rdata;
        logic        exp_exc;
        logic [31:0] exp_data;
        int          exp_stalls;
    } vec_t;

    vec_t vq[$];
    int n_pass = 0;
    int n_checks = 0;
    logic [31:0] last_data;

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic dm,
                                input int d, input logic [31:0] rd, input logic ex,
                                input logic [31:0] ed, input int es);
        vec_t v;
        v.op = op; v.addr = a; v.dmov = dm; v.delay = d; v.rdata = rd;
        v.exp_exc = ex; v.exp_data = ed; v.exp_stalls = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic do_load(input vec_t v);
        int stalls = 0;
        int waits = 0;
        bit seen_valid = 0;
        bit seen_req = 0;
        @(negedge clk);
        load = 1'b1; de_op = v.op; addr = v.addr; dmov = v.dmov;
        bus.rd_ack = 1'b0; bus.rd_data = 32'h0BAD_0BAD;
        #1;
        check("exc_adel", exc_adel, v.exp_exc);
        if (v.exp_exc) begin
            check("exc_stall", stall, 0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); #1;
                if (bus.rd_req) seen_req = 1;
            end
            check("exc_no_rd_req", seen_req, 0);
        end else begin
            for (int cyc = 0; cyc < 40 && !seen_valid; cyc++) begin
                if (cyc > 0) begin
                    @(negedge clk);
                    bus.rd_ack = 1'b0; bus.rd_data = 32'h0BAD_0BAD;
                    #1;
                end
                if (stall) stalls++;
                if (ld_valid) seen_valid = 1;
                else if (bus.rd_req) begin
                    if (!seen_req) check("rd_addr", bus.rd_addr, {v.addr[31:2], 2'b00});
                    seen_req = 1;
                    if (waits == v.delay) begin
                        bus.rd_ack = 1'b1; bus.rd_data = v.rdata;
                    end
                    waits++;
                end
            end
            check("ld_valid_seen", seen_valid, 1);
            check("stall_cycles", stalls, v.exp_stalls);
            check("ld_data", ld_data, v.exp_data);
            check("no_bus_err", bus_err, 0);
            last_data = v.exp_data;
        end
        $display("load op=%0d addr=0x%08h dmov=%0b delay=%0d exc=%0b data=0x%08h stalls=%0d",
                 v.op, v.addr, v.dmov, v.delay, exc_adel, ld_data, stalls);
        @(negedge clk);
        load = 1'b0; dmov = 1'b0; bus.rd_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        bit got;
        reset = 1'b0; load = 1'b0; de_op = DE_NONE; addr = 32'h0; req = 1'b0; dmov = 1'b0;
        bus.rd_ack = 1'b0; bus.rd_data = 32'h0;
        last_data = 32'h0;

        vq.push_back(mk(DE_LB,  32'h0000_0003, 0, 0, 32'h80FF_FFFF, 0, 32'hFFFF_FF80, 2));
        vq.push_back(mk(DE_LHU, 32'h0000_0102, 0, 3, 32'h8001_1234, 0, 32'h0000_8001, 5));
        vq.push_back(mk(DE_LW,  32'h0000_7F04, 0, 1, 32'h1234_5678, 0, 32'h1234_5678, 3));
        vq.push_back(mk(DE_LH,  32'h0000_2002, 0, 0, 32'h8001_7ABC, 0, 32'hFFFF_8001, 2));
        vq.push_back(mk(DE_LBU, 32'h0000_0001, 0, 2, 32'h0000_9A00, 0, 32'h0000_009A, 4));
        vq.push_back(mk(DE_LB,  32'h0000_0002, 0, 0, 32'h007F_0000, 0, 32'h0000_007F, 2));
        vq.push_back(mk(DE_LW,  32'h0000_2FFC, 0, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 2));
        vq.push_back(mk(DE_LH,  32'h0000_0000, 0, 1, 32'h1234_F00D, 0, 32'hFFFF_F00D, 3));
        vq.push_back(mk(DE_LW,  32'h0000_7F18, 0, 0, 32'h0000_0042, 0, 32'h0000_0042, 2));
        vq.push_back(mk(DE_LH,  32'h0000_0001, 0, 0, 32'h0, 1, 32'h0, 0));
        vq.push_back(mk(DE_LB,  32'h0000_7F04, 0, 0, 32'h0, 1, 32'h0, 0));
        vq.push_back(mk(DE_LW,  32'h0000_3000, 0, 0, 32'h0, 1, 32'h0, 0));
        vq.push_back(mk(DE_LW,  32'h0000_0000, 1, 0, 32'h0, 1, 32'h0, 0));
        vq.push_back(mk(DE_LW,  32'h0000_7F0C, 0, 0, 32'h0, 1, 32'h0, 0));
        vq.push_back(mk(DE_LW,  32'h0000_7F1C, 0, 0, 32'h0, 1, 32'h0, 0));
        vq.push_back(mk(DE_LHU, 32'h0000_0003, 0, 0, 32'h0, 1, 32'h0, 0));
        vq.push_back(mk(DE_LW,  32'h0000_0002, 0, 0, 32'h0, 1, 32'h0, 0));
        vq.push_back(mk(DE_LBU, 32'h0000_7F10, 0, 0, 32'h0, 1, 32'h0, 0));

        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_rd_req", bus.rd_req, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_ld_valid", ld_valid, 0);
        check("rst_ld_data", ld_data, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_stall", stall, 0);
        $display("reset released");

        for (int i = 0; i < vq.size(); i++) do_load(vq[i]);

        // DEOp=NONE with a bad address: neither a load nor a fault.
        @(negedge clk);
        load = 1'b1; de_op = DE_NONE; addr = 32'h0000_0001; #1;
        check("none_exc", exc_adel, 0);
        check("none_stall", stall, 0);
        $display("none op: exc=%0b stall=%0b", exc_adel, stall);
        @(negedge clk); #1;
        check("none_no_req", bus.rd_req, 0);
        load = 1'b0;

        // Flush in the first WAIT cycle, ack two cycles later.
        @(negedge clk);
        load = 1'b1; de_op = DE_LW; addr = 32'h0000_0010; #1;
        check("drain_accept_stall", stall, 1);
        @(negedge clk); #1;
        check("drain_wait_req", bus.rd_req, 1);
        req = 1'b1;
        @(negedge clk); req = 1'b0; #1;
        check("drain_stall_load", stall, 1);
        check("drain_req_held", bus.rd_req, 1);
        @(negedge clk);
        load = 1'b0; bus.rd_ack = 1'b1; bus.rd_data = 32'h5555_5555; #1;
        check("drain_stall_noload", stall, 0);
        @(negedge clk); bus.rd_ack = 1'b0; #1;
        check("drain_req_drop", bus.rd_req, 0);
        check("drain_no_valid", ld_valid, 0);
        check("drain_data_kept", ld_data, last_data);
        @(negedge clk); #1;
        check("drain_no_valid2", ld_valid, 0);
        $display("drain: rd_req=%0b ld_valid=%0b ld_data=0x%08h", bus.rd_req, ld_valid, ld_data);

        // Timeout: no ack at all.
        @(negedge clk);
        load = 1'b1; de_op = DE_LW; addr = 32'h0000_0020; bus.rd_ack = 1'b0; #1;
        waits = 0; got = 0;
        for (int cyc = 0; cyc < 40 && !got; cyc++) begin
            if (cyc > 0) begin @(negedge clk); #1; end
            if (bus_err) got = 1;
            else if (bus.rd_req) waits++;
        end
        check("to_bus_err", got, 1);
        check("to_wait_cycles", waits, 16);
        check("to_ld_valid", ld_valid, 1);
        check("to_ld_data", ld_data, 0);
        check("to_rd_req", bus.rd_req, 0);
        check("to_stall", stall, 0);
        $display("timeout: waits=%0d bus_err=%0b ld_data=0x%08h", waits, got, ld_data);
        @(negedge clk); load = 1'b0; #1;
        check("to_err_pulse", bus_err, 0);
        check("to_valid_pulse", ld_valid, 0);

        // Reset asserted in the middle of a transfer.
        do_load(mk(DE_LW, 32'h0000_0040, 0, 0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 2));
        @(negedge clk);
        load = 1'b1; de_op = DE_LW; addr = 32'h0000_0044;
        @(negedge clk); #1;
        check("mid_wait_req", bus.rd_req, 1);
        load = 1'b0; reset = 1'b0; #1;
        check("mid_rst_rd_req", bus.rd_req, 0);
        check("mid_rst_rd_addr", bus.rd_addr, 0);
        check("mid_rst_ld_data", ld_data, 0);
        check("mid_rst_ld_valid", ld_valid, 0);
        check("mid_rst_bus_err", bus_err, 0);
        check("mid_rst_stall", stall, 0);
        $display("mid-transfer reset: rd_req=%0b ld_data=0x%08h", bus.rd_req, ld_data);
        @(negedge clk); reset = 1'b1;
        do_load(vq[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
